// File: rtl/vga_pixel_feeder_if.sv
// Pixel-stream bus between the memory reader, the pixel feeder and the VGA timing stage.
interface vga_pixel_feeder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
);

  logic              frame_sync;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              fill_req;
  logic              data_req;
  logic [DATA_W-1:0] pixel_data;
  logic [ADDR_W:0]   level;
  logic              underflow;
  logic [15:0]       underflow_cnt;

  // Stimulus side: memory reader plus VGA timing stage.
  modport master (
    output frame_sync,
    output wr_valid,
    output wr_data,
    output data_req,
    input  wr_ready,
    input  fill_req,
    input  pixel_data,
    input  level,
    input  underflow,
    input  underflow_cnt
  );

  // Feeder side.
  modport slave (
    input  frame_sync,
    input  wr_valid,
    input  wr_data,
    input  data_req,
    output wr_ready,
    output fill_req,
    output pixel_data,
    output level,
    output underflow,
    output underflow_cnt
  );

endinterface

// File: rtl/vga_pixel_feeder.sv
// Pixel FIFO feeding the VGA timing stage: one registered pixel per data_req,
// burst refill requests, underflow debug counters and frame-sync flush.
module vga_pixel_feeder #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 9,
  parameter int unsigned       BURST      = 64,
  parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  vga_pixel_feeder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 16;

  // BURST must not exceed DEPTH, otherwise the refill threshold would go negative.
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] FILL_THR = LVL_W'(DEPTH - BURST);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic              underflow_q, underflow_d;
  logic [CNT_W-1:0]  ucnt_q, ucnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic mem_we;

  // Next-state: flush has priority, otherwise independent push/pop with underflow fill.
  always_comb begin
    full        = (level_q == DEPTH_L);
    empty       = (level_q == '0);
    push        = bus.wr_valid && !full;
    pop         = bus.data_req && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pixel_d     = pixel_q;
    underflow_d = underflow_q;
    ucnt_d      = ucnt_q;
    mem_we      = 1'b0;

    if (bus.frame_sync) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      if (bus.data_req) begin
        pixel_d = FILL_COLOR;
      end
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        pixel_d  = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else if (bus.data_req) begin
        // Empty FIFO: no bypass of a coincident push, the request underflows.
        pixel_d     = FILL_COLOR;
        underflow_d = 1'b1;
        if (ucnt_q != '1) begin
          ucnt_d = ucnt_q + CNT_W'(1);
        end
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pixel_q     <= '0;
      underflow_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pixel_q     <= pixel_d;
      underflow_q <= underflow_d;
      ucnt_q      <= ucnt_d;
    end
  end

  // Pixel storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready      = !full;
  assign bus.fill_req      = (level_q <= FILL_THR);
  assign bus.level         = level_q;
  assign bus.pixel_data    = pixel_q;
  assign bus.underflow     = underflow_q;
  assign bus.underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Bench for vga_pixel_feeder: behavioural queue model, pixel scoreboard,
// a constant vector table and hand-written corner sequences.
module tb_vga_pixel_feeder;

  localparam logic [15:0] FILL = 16'hF800;

  logic clk = 1'b0;
  logic rst;

  vga_pixel_feeder_if #(.DATA_W(16), .ADDR_W(9)) bus ();

  vga_pixel_feeder #(
    .DATA_W    (16),
    .ADDR_W    (9),
    .BURST     (64),
    .FILL_COLOR(FILL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [15:0] mq [$];
  logic [15:0] sb_q [$];
  logic [15:0] m_pix = 16'h0;
  bit          m_uf  = 1'b0;
  int          m_cnt = 0;

  typedef struct {
    bit          wv;
    logic [15:0] wd;
    bit          dr;
    int          exp_lvl;
    bit          chk_pix;
    logic [15:0] exp_pix;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic tick(input bit r, input bit fs, input bit wv, input logic [15:0] wd, input bit dr);
    bit          was_full;
    logic [15:0] exp_pix;
    was_full = (mq.size() == 512);
    rst            = r;
    bus.frame_sync = fs;
    bus.wr_valid   = wv;
    bus.wr_data    = wd;
    bus.data_req   = dr;
    if (r) begin
      mq.delete();
      sb_q.push_back(16'h0);
      m_uf  = 1'b0;
      m_cnt = 0;
    end else if (fs) begin
      mq.delete();
      if (dr) sb_q.push_back(FILL);
    end else begin
      if (dr) begin
        if (mq.size() != 0) begin
          sb_q.push_back(mq.pop_front());
        end else begin
          sb_q.push_back(FILL);
          m_uf = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (wv && !was_full) mq.push_back(wd);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      exp_pix = sb_q.pop_front();
      m_pix   = exp_pix;
    end
    chk("pixel_data",    32'(bus.pixel_data),    32'(m_pix));
    chk("level",         32'(bus.level),         32'(mq.size()));
    chk("wr_ready",      32'(bus.wr_ready),      32'(mq.size() < 512));
    chk("fill_req",      32'(bus.fill_req),      32'(mq.size() <= 448));
    chk("underflow",     32'(bus.underflow),     32'(m_uf));
    chk("underflow_cnt", 32'(bus.underflow_cnt), 32'(m_cnt));
  endtask

  initial begin
    int cnt_before;
    logic [15:0] d;

    // Push 1..5 then pop 5, then one idle cycle holding the last pixel.
    tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 16'h0002, 1'b0, 2, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 16'h0003, 1'b0, 3, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 16'h0004, 1'b0, 4, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 16'h0005, 1'b0, 5, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 4, 1'b1, 16'h0001};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 3, 1'b1, 16'h0002};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 2, 1'b1, 16'h0003};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1, 1'b1, 16'h0004};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 0, 1'b1, 16'h0005};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 0, 1'b1, 16'h0005};

    rst = 1'b1; bus.frame_sync = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 16'hAAAA; bus.data_req = 1'b0;

    // Reset with wr_valid held high.
    tick(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_pixel", 32'(bus.pixel_data), 32'd0);
    chk("rst_fill_req", 32'(bus.fill_req), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, 1'b0, tbl[i].wv, tbl[i].wd, tbl[i].dr);
      chk("tbl_level", 32'(bus.level), 32'(tbl[i].exp_lvl));
      if (tbl[i].chk_pix) chk("tbl_pixel", 32'(bus.pixel_data), 32'(tbl[i].exp_pix));
      chk("tbl_underflow", 32'(bus.underflow), 32'd0);
    end

    // Fill to full, watching the refill and ready thresholds.
    d = 16'h1000;
    for (int i = 0; i < 512; i++) begin
      tick(1'b0, 1'b0, 1'b1, d, 1'b0);
      d = d + 16'd1;
      if (i == 447) chk("fill_req_at_448", 32'(bus.fill_req), 32'd1);
      if (i == 448) chk("fill_req_at_449", 32'(bus.fill_req), 32'd0);
      if (i == 510) chk("wr_ready_at_511", 32'(bus.wr_ready), 32'd1);
    end
    chk("full_level", 32'(bus.level), 32'd512);
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    // Push attempt while full plus pop: only the pop happens.
    tick(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b1);
    chk("full_pop_level", 32'(bus.level), 32'd511);
    chk("full_pop_ready", 32'(bus.wr_ready), 32'd1);
    chk("full_pop_pixel", 32'(bus.pixel_data), 32'h1000);
    for (int i = 0; i < 511; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("drain1_last", 32'(bus.pixel_data), 32'h11FF);

    // Second pass across the pointer wrap.
    d = 16'h2000;
    for (int i = 0; i < 512; i++) begin
      tick(1'b0, 1'b0, 1'b1, d, 1'b0);
      d = d + 16'd1;
    end
    for (int i = 0; i < 512; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("drain2_last", 32'(bus.pixel_data), 32'h21FF);
    chk("drain2_level", 32'(bus.level), 32'd0);
    chk("no_underflow_yet", 32'(bus.underflow), 32'd0);

    // Underflow on empty, then push coincident with request on empty.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("uf_pixel", 32'(bus.pixel_data), 32'(FILL));
    chk("uf_flag", 32'(bus.underflow), 32'd1);
    chk("uf_cnt3", 32'(bus.underflow_cnt), 32'd3);
    tick(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
    chk("uf_push_level", 32'(bus.level), 32'd1);
    chk("uf_cnt4", 32'(bus.underflow_cnt), 32'd4);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("uf_stored_pixel", 32'(bus.pixel_data), 32'h1234);

    // Frame sync at level 100 with coincident push and request.
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 1'b1, 16'(16'h3000 + i), 1'b0);
    cnt_before = 32'(bus.underflow_cnt);
    tick(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1);
    chk("fs_level", 32'(bus.level), 32'd0);
    chk("fs_pixel", 32'(bus.pixel_data), 32'(FILL));
    chk("fs_cnt", 32'(bus.underflow_cnt), 32'(cnt_before));
    chk("fs_uf_kept", 32'(bus.underflow), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 16'h0ABC, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("fs_first_pixel", 32'(bus.pixel_data), 32'h0ABC);
    // Frame sync without a request holds the pixel.
    tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("fs_hold_pixel", 32'(bus.pixel_data), 32'h0ABC);

    // Reset mid-burst discards buffered pixels.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 16'(16'h4000 + i), 1'b0);
    tick(1'b1, 1'b1, 1'b1, 16'h0, 1'b1);
    chk("midrst_level", 32'(bus.level), 32'd0);
    chk("midrst_cnt", 32'(bus.underflow_cnt), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 16'h7777, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("midrst_pixel", 32'(bus.pixel_data), 32'h7777);

    // Counter saturation, then cleared by reset.
    for (int i = 0; i < 65540; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("sat_cnt", 32'(bus.underflow_cnt), 32'hFFFF);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("sat_rst_cnt", 32'(bus.underflow_cnt), 32'd0);
    chk("sat_rst_flag", 32'(bus.underflow), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_feeder.md
Name: vga_pixel_feeder

Overview:
- Upstream pixel source for the VGA timing stage: buffers a 16-bit RGB565 pixel stream (memory or camera read side) in an internal FIFO.
- Returns one pixel per data_req pulse, registered, one cycle later on pixel_data.
- Issues burst-sized refill requests to the memory reader and counts underflows for debug.
- Flushes on a frame-sync pulse so every frame starts pixel-aligned.

Parameters:
- DATA_W, 16, pixel width (RGB565).
- ADDR_W, 9, FIFO address width; depth = 2**ADDR_W = 512 entries.
- BURST, 64, refill granularity in pixels; must be less than or equal to depth.
- FILL_COLOR, 16'h0000, pixel value returned on underflow.

Ports:
- clk  in  1  system clock (the VGA pixel-domain clock; single clock).
- rst  in  1  synchronous, active-high reset.
- frame_sync  in  1  one-cycle pulse at frame start; flushes the FIFO.
- wr_valid  in  1  upstream pixel valid.
- wr_data  in  DATA_W  upstream pixel.
- wr_ready  out  1  FIFO can accept; equals !full.
- fill_req  out  1  level <= depth-BURST, so a whole BURST fits.
- data_req  in  1  pixel request from VGA timing stage.
- pixel_data  out  DATA_W  requested pixel, registered.
- level  out  ADDR_W+1  current FIFO occupancy, 0..depth.
- underflow  out  1  sticky flag: data_req seen while empty.
- underflow_cnt  out  16  saturating count of underflowed requests.

Behaviour:
- Reset (rst=1 at a clk edge) produces the following state:
  - pointers=0, level=0, pixel_data=0, underflow=0, underflow_cnt=0.
  - wr_ready=1, fill_req=1 (combinational from level).
- Storage: circular buffer with wr_ptr/rd_ptr of ADDR_W bits that wrap modulo depth.
  - level is an explicit ADDR_W+1-bit counter.
  - full = (level==depth); empty = (level==0).
- Push occurs when wr_valid && wr_ready. Writes wr_data at wr_ptr, then wr_ptr+1.
- Pop occurs when data_req && !empty. Reads at rd_ptr, then rd_ptr+1.
- Latency: data_req sampled at edge N; pixel_data holds the popped pixel from edge N+1 until the next data_req.
  - Back-to-back data_req every cycle yields a new pixel every cycle. No bubbles while the FIFO is non-empty.
- Underflow: data_req && empty at edge N has these effects:
  - pixel_data=FILL_COLOR at N+1.
  - underflow set (sticky until rst).
  - underflow_cnt+1, saturating at 16'hFFFF.
  - No pointer change.
- Simultaneous push and pop:
  - Non-empty, not full: both occur and level is unchanged.
  - Empty: no bypass. The push is stored and the pop is treated as an underflow. Level becomes 1.
  - Full: wr_ready=0, so no push; the pop proceeds and level becomes depth-1.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither. level never exceeds depth and never goes below 0.
- frame_sync has priority over push and pop in the same cycle:
  - Pointers and level go to 0. A coincident push is dropped and a coincident pop is not performed.
  - If data_req coincides, pixel_data=FILL_COLOR but underflow and underflow_cnt are not affected.
  - Otherwise pixel_data holds its value.
  - underflow and underflow_cnt are preserved across frame_sync; only rst clears them.
- rst priority: rst overrides frame_sync and all other inputs. Reset asserted mid-burst discards all buffered pixels.
- fill_req and wr_ready are combinational from level; they update in the cycle after the push or pop edge.
- Data held in the RAM is undefined after reset/flush. It is never observable, because reads occur only when non-empty.

Test Plan:
- Reset with wr_valid=1 asserted → level=0, wr_ready=1, fill_req=1, pixel_data=0, underflow=0 during and after the reset cycle.
- Push 0x0001..0x0005 on consecutive cycles, then data_req for 5 consecutive cycles → pixel_data = 0x0001..0x0005 on cycles N+1..N+5, level 5→0, underflow stays 0.
- Fill to 512 (wr_ready drops at level=512; fill_req drops at level=449). Then one cycle with data_req=1 and wr_valid=1 → no push, level=511, wr_ready=1 on the next cycle. Pointer wrap is checked by a second 512-pixel pass with incrementing data matching exactly.
- Empty FIFO, data_req for 3 cycles with FILL_COLOR=0xF800 → pixel_data=0xF800, underflow=1, underflow_cnt=3. Same-cycle push and data_req on empty → level=1, underflow_cnt=4.
- Level=100, then frame_sync coincident with wr_valid and data_req → level=0, pixel_data=FILL_COLOR, underflow_cnt unchanged. The next pushed pixel is the first one read.
- Force 65,540 underflows → underflow_cnt saturates at 0xFFFF. rst then clears it to 0.
